// File: rtl/alu_pkg.sv
// Shared definitions for the alu_32 request issuer: op codes, RV32I/M
// opcode and funct fields, flag bit positions and FSM state encoding.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_BEQ    = 5'd14,
    OP_BNE    = 5'd15,
    OP_BLT    = 5'd16,
    OP_BGE    = 5'd17,
    OP_BLTU   = 5'd18,
    OP_BGEU   = 5'd19
  } alu_op_e;

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct7 variants
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // funct3 for integer ops
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct3 for M extension
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  // funct3 for branches
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Bit positions inside rsp_flags = {cmp,n,v,z}
  localparam int FLAG_Z   = 0;
  localparam int FLAG_V   = 1;
  localparam int FLAG_N   = 2;
  localparam int FLAG_CMP = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } issuer_state_e;

endpackage

// File: rtl/alu_inst_encoder.sv
// Combinational translation of an abstract ALU request into the RV32I/M
// instruction word alu_32 decodes. rd/rs1/rs2 are always zero because
// operands reach alu_32 directly on its a/b ports.
module alu_inst_encoder
  import alu_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [11:0] imm_i,
  input  logic        use_imm_i,
  output logic [31:0] inst_o,
  output logic        illegal_o
);

  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic       known_s;
  logic       branch_s;
  logic       imm_ok_s;
  logic       shift_s;

  // Classify the op and pick its funct3/funct7 fields
  always_comb begin
    funct3_s = F3_ADD;
    funct7_s = F7_BASE;
    known_s  = 1'b1;
    branch_s = 1'b0;
    imm_ok_s = 1'b1;
    shift_s  = 1'b0;
    case (op_i)
      OP_ADD:    funct3_s = F3_ADD;
      OP_SUB:    begin funct3_s = F3_ADD; funct7_s = F7_ALT; imm_ok_s = 1'b0; end
      OP_SLL:    begin funct3_s = F3_SLL; shift_s = 1'b1; end
      OP_SLT:    funct3_s = F3_SLT;
      OP_SLTU:   funct3_s = F3_SLTU;
      OP_XOR:    funct3_s = F3_XOR;
      OP_SRL:    begin funct3_s = F3_SR; shift_s = 1'b1; end
      OP_SRA:    begin funct3_s = F3_SR; funct7_s = F7_ALT; shift_s = 1'b1; end
      OP_OR:     funct3_s = F3_OR;
      OP_AND:    funct3_s = F3_AND;
      OP_MUL:    begin funct3_s = F3_MUL;    funct7_s = F7_MULDIV; imm_ok_s = 1'b0; end
      OP_MULH:   begin funct3_s = F3_MULH;   funct7_s = F7_MULDIV; imm_ok_s = 1'b0; end
      OP_MULHSU: begin funct3_s = F3_MULHSU; funct7_s = F7_MULDIV; imm_ok_s = 1'b0; end
      OP_MULHU:  begin funct3_s = F3_MULHU;  funct7_s = F7_MULDIV; imm_ok_s = 1'b0; end
      OP_BEQ:    begin funct3_s = F3_BEQ;  branch_s = 1'b1; imm_ok_s = 1'b0; end
      OP_BNE:    begin funct3_s = F3_BNE;  branch_s = 1'b1; imm_ok_s = 1'b0; end
      OP_BLT:    begin funct3_s = F3_BLT;  branch_s = 1'b1; imm_ok_s = 1'b0; end
      OP_BGE:    begin funct3_s = F3_BGE;  branch_s = 1'b1; imm_ok_s = 1'b0; end
      OP_BLTU:   begin funct3_s = F3_BLTU; branch_s = 1'b1; imm_ok_s = 1'b0; end
      OP_BGEU:   begin funct3_s = F3_BGEU; branch_s = 1'b1; imm_ok_s = 1'b0; end
      default:   begin known_s = 1'b0; imm_ok_s = 1'b0; end
    endcase
  end

  // Assemble the instruction word for the selected format
  always_comb begin
    inst_o    = 32'h0000_0000;
    illegal_o = 1'b0;
    if (!known_s || (use_imm_i && !imm_ok_s)) begin
      illegal_o = 1'b1;
    end else if (branch_s) begin
      // inst[30] steers alu_32 onto its subtract path for the compare
      inst_o = {1'b0, 1'b1, 5'b00000, 5'b00000, 5'b00000, funct3_s, 5'b00000, OPC_BRANCH};
    end else if (use_imm_i) begin
      if (shift_s) begin
        inst_o = {funct7_s, imm_i[4:0], 5'b00000, funct3_s, 5'b00000, OPC_OP_IMM};
      end else begin
        inst_o = {imm_i, 5'b00000, funct3_s, 5'b00000, OPC_OP_IMM};
      end
    end else begin
      inst_o = {funct7_s, 5'b00000, 5'b00000, funct3_s, 5'b00000, OPC_OP};
    end
  end

endmodule

// File: rtl/alu_inst_issuer.sv
// Initiator for alu_32: accepts one request at a time, drives a/b/inst,
// lets the ALU settle, then holds the captured result until consumed.
module alu_inst_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [11:0]      req_imm,
  input  logic             req_use_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [31:0]      alu_inst,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_n,
  input  logic             alu_cmp,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_illegal
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  issuer_state_e    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [31:0]      alu_inst_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic [3:0]       rsp_flags_q;
  logic             rsp_illegal_q;

  logic [WIDTH-1:0] alu_b_d;
  logic [3:0]       flags_d;
  logic [31:0]      enc_inst_s;
  logic             enc_illegal_s;

  alu_inst_encoder u_encoder (
    .op_i      (req_op),
    .imm_i     (req_imm),
    .use_imm_i (req_use_imm),
    .inst_o    (enc_inst_s),
    .illegal_o (enc_illegal_s)
  );

  // Second ALU operand: register operand or sign-extended immediate
  always_comb begin
    alu_b_d = req_b;
    if (req_use_imm) begin
      alu_b_d = {{(WIDTH-12){req_imm[11]}}, req_imm};
    end else begin
      alu_b_d = req_b;
    end
  end

  // Pack alu_32 flags into the response flag layout
  always_comb begin
    flags_d           = 4'b0000;
    flags_d[FLAG_Z]   = alu_z;
    flags_d[FLAG_V]   = alu_v;
    flags_d[FLAG_N]   = alu_n;
    flags_d[FLAG_CMP] = alu_cmp;
  end

  // Request/settle/response sequencing and all held outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_inst_q    <= 32'h0000_0000;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_flags_q   <= 4'b0000;
      rsp_illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (enc_illegal_s) begin
              // Nothing reaches the ALU; answer immediately
              rsp_valid_q   <= 1'b1;
              rsp_illegal_q <= 1'b1;
              rsp_result_q  <= '0;
              rsp_flags_q   <= 4'b0000;
              state_q       <= ST_RESP;
            end else begin
              alu_a_q    <= req_a;
              alu_b_q    <= alu_b_d;
              alu_inst_q <= enc_inst_s;
              cnt_q      <= '0;
              state_q    <= ST_ISSUE;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (cnt_q == CNT_LAST) begin
            rsp_valid_q   <= 1'b1;
            rsp_illegal_q <= 1'b0;
            rsp_result_q  <= alu_out;
            rsp_flags_q   <= flags_d;
            cnt_q         <= '0;
            state_q       <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            state_q <= ST_RESP;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Ready is suppressed while reset is asserted even though the state is IDLE
  assign req_ready   = (state_q == ST_IDLE) && !rst;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_inst    = alu_inst_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_flags   = rsp_flags_q;
  assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_inst_issuer.sv
// Bench for alu_inst_issuer: a behavioural alu_32 stand-in decodes the
// issued word, and a reference model computes the expected response from
// the abstract request.
module tb_alu_inst_issuer;

  localparam int W      = 32;
  localparam int SETTLE = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_op;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic [11:0]   req_imm;
  logic          req_use_imm;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [31:0]   alu_inst;
  logic [W-1:0]  alu_out;
  logic          alu_z;
  logic          alu_v;
  logic          alu_n;
  logic          alu_cmp;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_result;
  logic [3:0]    rsp_flags;
  logic          rsp_illegal;

  int checks   = 0;
  int failures = 0;

  logic [31:0] prev_a, prev_b, prev_inst;
  logic [31:0] obs_inst, obs_result;
  logic [3:0]  obs_flags;
  logic        obs_illegal;
  int          obs_lat;

  alu_inst_issuer #(.WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_imm     (req_imm),
    .req_use_imm (req_use_imm),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_inst    (alu_inst),
    .alu_out     (alu_out),
    .alu_z       (alu_z),
    .alu_v       (alu_v),
    .alu_n       (alu_n),
    .alu_cmp     (alu_cmp),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags),
    .rsp_illegal (rsp_illegal)
  );

  always #5 clk = ~clk;

  // RV32I/M field tables indexed by op number
  localparam logic [2:0] F3T [20] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7,
                                      3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  // ALU semantics by abstract op: returns {cmp, n, v, z, result}
  function automatic logic [35:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [63:0] p;
    logic        c, v;
    r = 32'h0; p = 64'h0; c = 1'b0; v = 1'b0;
    case (op)
      5'd0:  begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      5'd1:  begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      5'd2:  r = a << b[4:0];
      5'd3:  r = {31'h0, $signed(a) < $signed(b)};
      5'd4:  r = {31'h0, a < b};
      5'd5:  r = a ^ b;
      5'd6:  r = a >> b[4:0];
      5'd7:  r = $unsigned($signed(a) >>> b[4:0]);
      5'd8:  r = a | b;
      5'd9:  r = a & b;
      5'd10: r = a * b;
      5'd11: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
      5'd12: begin p = {{32{a[31]}}, a} * {32'h0, b};       r = p[63:32]; end
      5'd13: begin p = {32'h0, a} * {32'h0, b};             r = p[63:32]; end
      5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19: begin
        r = a - b;
        v = (a[31] != b[31]) && (r[31] != a[31]);
        case (op)
          5'd14:   c = (a == b);
          5'd15:   c = (a != b);
          5'd16:   c = ($signed(a) < $signed(b));
          5'd17:   c = ($signed(a) >= $signed(b));
          5'd18:   c = (a < b);
          default: c = (a >= b);
        endcase
      end
      default: r = 32'h0;
    endcase
    return {c, r[31], v, (r == 32'h0), r};
  endfunction

  // Instruction word back to abstract op (31 when not recognised)
  function automatic logic [4:0] dec(input logic [31:0] inst);
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] o;
    f3 = inst[14:12];
    f7 = inst[31:25];
    o  = 5'd31;
    if (inst[6:0] == 7'h63) begin
      case (f3)
        3'd0: o = 5'd14;  3'd1: o = 5'd15;  3'd4: o = 5'd16;
        3'd5: o = 5'd17;  3'd6: o = 5'd18;  3'd7: o = 5'd19;
        default: o = 5'd31;
      endcase
    end else if (inst[6:0] == 7'h33 && f7 == 7'h01) begin
      o = (f3 < 3'd4) ? (5'd10 + {2'b00, f3}) : 5'd31;
    end else if (inst[6:0] == 7'h33 || inst[6:0] == 7'h13) begin
      case (f3)
        3'd0: o = (inst[6:0] == 7'h33 && f7[5]) ? 5'd1 : 5'd0;
        3'd1: o = 5'd2;  3'd2: o = 5'd3;  3'd3: o = 5'd4;  3'd4: o = 5'd5;
        3'd5: o = f7[5] ? 5'd7 : 5'd6;
        3'd6: o = 5'd8;
        default: o = 5'd9;
      endcase
    end
    return o;
  endfunction

  // Expected {illegal, inst} built directly from the RV32I/M formats
  function automatic logic [32:0] exp_enc(input logic [4:0] op, input logic [11:0] imm, input logic ui);
    logic [2:0] f3;
    logic [6:0] f7;
    if (op > 5'd19) return {1'b1, 32'h0};
    if (ui && (op == 5'd1 || op >= 5'd10)) return {1'b1, 32'h0};
    f3 = F3T[op];
    f7 = (op == 5'd1 || op == 5'd7) ? 7'h20 : ((op >= 5'd10) ? 7'h01 : 7'h00);
    if (op >= 5'd14) return {1'b0, 32'h4000_0063 | {17'h0, f3, 12'h0}};
    if (ui && (op == 5'd2 || op == 5'd6 || op == 5'd7))
      return {1'b0, f7, imm[4:0], 5'h0, f3, 5'h0, 7'h13};
    if (ui) return {1'b0, imm, 5'h0, f3, 5'h0, 7'h13};
    return {1'b0, f7, 10'h0, f3, 5'h0, 7'h33};
  endfunction

  // alu_32 stand-in: purely combinational from the issued word
  always_comb begin
    {alu_cmp, alu_n, alu_v, alu_z, alu_out} = alu_fn(dec(alu_inst), alu_a, alu_b);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction starting at a negedge with the issuer idle
  task automatic run_txn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [11:0] imm, input logic ui, input int stall);
    logic [32:0] enc;
    logic [31:0] b_eff;
    logic [35:0] m;
    logic        ill;
    int          lat;
    enc   = exp_enc(op, imm, ui);
    ill   = enc[32];
    b_eff = ui ? {{20{imm[11]}}, imm} : b;
    m     = alu_fn(op, a, b_eff);
    chk("ready_idle", {63'h0, req_ready}, 64'h1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_imm = imm; req_use_imm = ui;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 5'($urandom); req_a = $urandom; req_b = $urandom;
    req_imm = 12'($urandom); req_use_imm = 1'($urandom);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), ill ? 64'd1 : 64'(SETTLE + 1));
    if (!ill) begin
      prev_a = a; prev_b = b_eff; prev_inst = enc[31:0];
    end else begin
      prev_inst = prev_inst;
    end
    chk("alu_inst", {32'h0, alu_inst}, {32'h0, prev_inst});
    chk("alu_a", {32'h0, alu_a}, {32'h0, prev_a});
    chk("alu_b", {32'h0, alu_b}, {32'h0, prev_b});
    chk("rsp_illegal", {63'h0, rsp_illegal}, {63'h0, ill});
    chk("rsp_result", {32'h0, rsp_result}, ill ? 64'h0 : {32'h0, m[31:0]});
    chk("rsp_flags", {60'h0, rsp_flags}, ill ? 64'h0 : {60'h0, m[35:32]});
    chk("ready_resp", {63'h0, req_ready}, 64'h0);
    obs_inst = alu_inst; obs_result = rsp_result; obs_flags = rsp_flags;
    obs_illegal = rsp_illegal; obs_lat = lat;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_valid", {63'h0, rsp_valid}, 64'h1);
      chk("hold_result", {32'h0, rsp_result}, {32'h0, obs_result});
      chk("hold_ready", {63'h0, req_ready}, 64'h0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("drain_valid", {63'h0, rsp_valid}, 64'h0);
    chk("drain_ready", {63'h0, req_ready}, 64'h1);
  endtask

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    rst = 1'b1; req_valid = 1'b0; req_op = 5'd0; req_a = 32'h0; req_b = 32'h0;
    req_imm = 12'h0; req_use_imm = 1'b0; rsp_ready = 1'b0;
    prev_a = 32'h0; prev_b = 32'h0; prev_inst = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {63'h0, req_ready}, 64'h0);
    chk("rst_valid", {63'h0, rsp_valid}, 64'h0);
    chk("rst_alu_inst", {32'h0, alu_inst}, 64'h0);
    chk("rst_alu_a", {32'h0, alu_a}, 64'h0);
    chk("rst_alu_b", {32'h0, alu_b}, 64'h0);
    chk("rst_result", {32'h0, rsp_result}, 64'h0);
    chk("rst_flags", {60'h0, rsp_flags}, 64'h0);
    chk("rst_illegal", {63'h0, rsp_illegal}, 64'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {63'h0, req_ready}, 64'h1);
    @(negedge clk);

    // ADD register form
    run_txn(5'd0, 32'h0101_FFFF, 32'h0011_FFFF, 12'h000, 1'b0, 0);
    chk("add_inst_lit", {32'h0, obs_inst}, 64'h0000_0033);
    chk("add_result_lit", {32'h0, obs_result}, 64'h0113_FFFE);
    chk("add_lat_lit", 64'(obs_lat), 64'd2);

    // SRAI
    run_txn(5'd7, 32'hF871_ABCD, $urandom, 12'h003, 1'b1, 0);
    chk("srai_inst_lit", {32'h0, obs_inst}, 64'h4030_5013);
    chk("srai_result_lit", {32'h0, obs_result}, 64'hFF0E_3579);

    // BLTU both orders
    run_txn(5'd18, 32'hFFFF_FFF0, 32'hFFFF_FFF1, 12'h000, 1'b0, 0);
    chk("bltu_inst_lit", {32'h0, obs_inst}, 64'h4000_6063);
    chk("bltu_cmp_lit", {63'h0, obs_flags[3]}, 64'h1);
    run_txn(5'd18, 32'hFFFF_FFF1, 32'hFFFF_FFF0, 12'h000, 1'b0, 0);
    chk("bltu_swap_cmp_lit", {63'h0, obs_flags[3]}, 64'h0);

    // MUL with immediate is not encodable
    run_txn(5'd10, $urandom, $urandom, 12'h7FF, 1'b1, 0);
    chk("mul_imm_illegal", {63'h0, obs_illegal}, 64'h1);
    chk("mul_imm_result", {32'h0, obs_result}, 64'h0);
    chk("mul_imm_inst_kept", {32'h0, obs_inst}, 64'h4000_6063);
    chk("mul_imm_lat", 64'(obs_lat), 64'd1);

    // Backpressure on the response
    run_txn(5'd5, $urandom, $urandom, 12'h000, 1'b0, 5);
    run_txn(5'd9, $urandom, $urandom, 12'h000, 1'b0, 0);

    // Reset while the ALU is being driven
    req_valid = 1'b1; req_op = 5'd0; req_a = 32'h1234_5678; req_b = 32'h1111_1111;
    req_use_imm = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", {63'h0, rsp_valid}, 64'h0);
    chk("mid_rst_alu_a", {32'h0, alu_a}, 64'h0);
    chk("mid_rst_alu_b", {32'h0, alu_b}, 64'h0);
    chk("mid_rst_alu_inst", {32'h0, alu_inst}, 64'h0);
    chk("mid_rst_ready", {63'h0, req_ready}, 64'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {63'h0, req_ready}, 64'h1);
    prev_a = 32'h0; prev_b = 32'h0; prev_inst = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_stale_rsp", {63'h0, rsp_valid}, 64'h0);
    end

    // Randomized traffic including illegal ops and immediates
    for (int n = 0; n < 80; n++) begin
      rop = 5'($urandom_range(0, 23));
      case ($urandom_range(0, 4))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       rb = ra;
        1:       rb = 32'h7FFF_FFFF;
        default: rb = $urandom;
      endcase
      run_txn(rop, ra, rb, 12'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
